// File: rtl/aes_decrypt_iter_if.sv
// ---------------------------------------------------------------------------
// aes_decrypt_iter_if
// Request/response bundle for the iterative AES-128 decryptor.
//   start   : request strobe, sampled only while the core is idle
//   data    : [0:127] ciphertext, sampled with start (bit 0 = MSB)
//   key     : [0:127] cipher key (round key 0), sampled with start
//   busy    : operation in progress
//   done    : one-cycle pulse, de_data valid
//   de_data : [0:127] recovered plaintext, held until next completion/reset
// master drives the request side, slave is the decryptor.
// ---------------------------------------------------------------------------
interface aes_decrypt_iter_if;
  logic         start;
  logic [0:127] data;
  logic [0:127] key;
  logic         busy;
  logic         done;
  logic [0:127] de_data;

  modport master (output start, data, key, input  busy, done, de_data);
  modport slave  (input  start, data, key, output busy, done, de_data);
endinterface

// File: rtl/aes_decrypt_iter.sv
// ---------------------------------------------------------------------------
// aes_decrypt_iter
// Iterative AES-128 decryption, one round per clock, 20 cycles per block.
// The forward key schedule is run first (10 cycles) to reach round key 10,
// then the schedule is walked backwards while the inverse rounds execute.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : aes_decrypt_iter_if.slave (start/data/key in, busy/done/de_data out)
// Bit order: bit 0 is the MSB, byte n = bits [8n:8n+7], byte n sits at
// row n%4, column n/4.
// ---------------------------------------------------------------------------
module aes_decrypt_iter (
  input  logic              clk,
  input  logic              rst,
  aes_decrypt_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, KEXP, ROUND} state_e;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  // Rcon bytes indexed by cnt 0..9
  localparam logic [0:79] RCON = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:31] inv_mix_col(input logic [0:31] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[8*i +: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  state_e       state_q, state_d;
  logic [0:127] st_q, st_d;
  logic [0:127] rk_q, rk_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [0:127] de_q, de_d;

  // ---------------- key path ----------------
  logic [0:31]  w0, w1, w2, w3;
  logic [0:31]  f1, f2, f3, i1, i2, i3, nw0;
  logic [0:31]  sw_in, sw_rot, sw_out, rcon_w;
  logic [0:127] fwd_rk, inv_rk;

  always_comb begin
    w0 = rk_q[0:31];
    w1 = rk_q[32:63];
    w2 = rk_q[64:95];
    w3 = rk_q[96:127];
    rcon_w = {RCON[{cnt_q, 3'b000} +: 8], 24'h000000};
    // Backward step recovers w3..w1 by pure XOR; w0 then needs SubWord of the
    // recovered w3, so the single SubWord unit is fed from i3 in ROUND.
    i3 = w3 ^ w2;
    i2 = w2 ^ w1;
    i1 = w1 ^ w0;
    sw_in  = (state_q == ROUND) ? i3 : w3;
    sw_rot = {sw_in[8:31], sw_in[0:7]};
    sw_out = {sbox(sw_rot[0:7]), sbox(sw_rot[8:15]),
              sbox(sw_rot[16:23]), sbox(sw_rot[24:31])};
    // Same expression serves as w0' (forward) and w0 (backward).
    nw0 = w0 ^ sw_out ^ rcon_w;
    f1  = w1 ^ nw0;
    f2  = w2 ^ f1;
    f3  = w3 ^ f2;
    fwd_rk = {nw0, f1, f2, f3};
    inv_rk = {nw0, i1, i2, i3};
  end

  // ---------------- round datapath ----------------
  logic [0:127] isb, t, imc;

  always_comb begin
    isb = '0;
    imc = '0;
    // InvShiftRows: row r rotates right by r, so out(r,c) = in(r,(c-r)%4)
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        isb[8*(4*c+r) +: 8] = inv_sbox(st_q[8*(4*((c-r+4)%4)+r) +: 8]);
    t = isb ^ inv_rk;
    for (int c = 0; c < 4; c++)
      imc[32*c +: 32] = inv_mix_col(t[32*c +: 32]);
  end

  // ---------------- control ----------------
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rk_d    = rk_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    de_d    = de_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          st_d    = bus.data;
          rk_d    = bus.key;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = KEXP;
        end
      end
      KEXP: begin
        rk_d = fwd_rk;
        if (cnt_q == 4'd9) begin
          st_d    = st_q ^ fwd_rk;   // initial AddRoundKey with round key 10
          state_d = ROUND;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ROUND: begin
        rk_d = inv_rk;
        if (cnt_q == 4'd0) begin
          st_d    = t;
          de_d    = t;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          st_d  = imc;
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      de_q    <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      de_q    <= de_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.de_data = de_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt_iter
// Scoreboard bench: expected plaintexts are queued when a start is driven and
// popped by a monitor whenever done pulses. The random cross-check uses a
// bench-local AES-128 encryptor whose S-box is derived from GF(2^8) inversion.
// ---------------------------------------------------------------------------
module tb_aes_decrypt_iter;

  logic clk = 1'b0;
  logic rst;

  aes_decrypt_iter_if bus ();

  aes_decrypt_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [0:127] exp_q [$];
  logic [0:127] mon_exp;
  logic [7:0]   sb [256];

  localparam logic [0:127] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int i = 0; i < 256; i++) begin
      x   = 8'(i);
      inv = 8'h00;
      if (i != 0) begin
        inv = 8'h01;
        for (int j = 0; j < 254; j++) inv = gmul(inv, x);
      end
      sb[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [0:127] aes_enc(input logic [0:127] key, input logic [0:127] pt);
    logic [0:127] s, k, u;
    logic [0:31]  w;
    logic [7:0]   rc, a0, a1, a2, a3;
    s  = pt ^ key;
    k  = key;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      w = {k[104:127], k[96:103]};
      w = {sb[w[0:7]], sb[w[8:15]], sb[w[16:23]], sb[w[24:31]]} ^ {rc, 24'h000000};
      k[0:31]   = k[0:31]   ^ w;
      k[32:63]  = k[32:63]  ^ k[0:31];
      k[64:95]  = k[64:95]  ^ k[32:63];
      k[96:127] = k[96:127] ^ k[64:95];
      rc = gmul(rc, 8'h02);
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          u[8*(4*c+rr) +: 8] = sb[s[8*(4*((c+rr)%4)+rr) +: 8]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = u[32*c +: 8]; a1 = u[32*c+8 +: 8]; a2 = u[32*c+16 +: 8]; a3 = u[32*c+24 +: 8];
          s[32*c    +: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[32*c+8  +: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[32*c+16 +: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[32*c+24 +: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end else begin
        s = u;
      end
      s = s ^ k;
    end
    return s;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: de_data=%h with no result pending", bus.de_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.de_data !== mon_exp) begin
          errors++;
          $display("FAIL plaintext: got %h, expected %h", bus.de_data, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.data  = '0;
    bus.key   = '0;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", bus.done); end
    checks++;
    if (bus.de_data !== 128'h0) begin errors++; $display("FAIL reset_de_data: got %h, expected 0", bus.de_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_known_vectors();
    logic [0:127] kv [3], cv [3], pv [3];
    int bad;
    kv[0] = KEY_B;  cv[0] = CT_B;  pv[0] = PT_B;
    kv[1] = KEY_C;  cv[1] = CT_C;  pv[1] = PT_C;
    kv[2] = '0;     cv[2] = CT_Z;  pv[2] = '0;
    for (int v = 0; v < 3; v++) begin
      bus.key = kv[v];
      bus.data = cv[v];
      bus.start = 1'b1;
      exp_q.push_back(pv[v]);
      tick();                       // accepting edge T
      bus.start = 1'b0;
      bus.data = rnd128();          // inputs need not be held after sampling
      bus.key  = rnd128();
      bad = 0;
      for (int k = 1; k <= 19; k++) begin
        tick();
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL busy_window vec%0d: %0d bad cycles, expected 0", v, bad); end
      tick();                       // edge T+20
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL latency vec%0d: done=%b busy=%b, expected done=1 busy=0", v, bus.done, bus.busy);
      end
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.de_data !== pv[v]) begin
        errors++; $display("FAIL done_pulse_hold vec%0d: done=%b de_data=%h, expected done=0 de_data=%h", v, bus.done, bus.de_data, pv[v]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    bus.key = KEY_B;
    bus.data = CT_B;
    bus.start = 1'b1;
    exp_q.push_back(PT_B);
    tick();                         // T
    bus.start = 1'b0;
    bad = 0;
    for (int k = 1; k <= 19; k++) begin
      tick();                       // after edge T+k
      if (bus.busy !== 1'b1) bad++;
      bus.start = (k == 5 || k == 12);
      if (bus.start) begin
        bus.data = rnd128();
        bus.key  = rnd128();
      end
    end
    bus.start = 1'b0;
    tick();                         // T+20
    checks++;
    if (bad != 0 || bus.done !== 1'b1) begin
      errors++; $display("FAIL b2b_first: bad_busy=%0d done=%b, expected 0 and 1", bad, bus.done);
    end
    bus.key = KEY_C;
    bus.data = CT_C;
    bus.start = 1'b1;               // start in the done cycle
    exp_q.push_back(PT_C);
    tick();                         // T+21 accepts
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: busy=%b done=%b, expected 1 0", bus.busy, bus.done);
    end
    for (int k = 1; k <= 19; k++) tick();
    tick();                         // T+41
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_second_latency: done=%b, expected 1", bus.done); end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen, n;
    bus.key = KEY_B;
    bus.data = CT_B;
    bus.start = 1'b1;               // aborted: nothing queued
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.de_data !== 128'h0) begin
      errors++; $display("FAIL reset_mid: busy=%b done=%b de_data=%h, expected 0 0 0", bus.busy, bus.done, bus.de_data);
    end
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_mid_quiet: %0d active cycles, expected 0", seen); end
    bus.key = KEY_C;
    bus.data = CT_C;
    bus.start = 1'b1;
    exp_q.push_back(PT_C);
    tick();
    bus.start = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.done !== 1'b1 && n < 30);
    checks++;
    if (n != 20) begin errors++; $display("FAIL reset_mid_restart: latency %0d, expected 20", n); end
    tick();
  endtask

  task automatic test_random_xcheck();
    logic [0:127] k, p;
    int n;
    for (int i = 0; i < 1000; i++) begin
      k = rnd128();
      p = rnd128();
      bus.key = k;
      bus.data = aes_enc(k, p);
      bus.start = 1'b1;             // held high: restart straight from the done cycle
      exp_q.push_back(p);
      tick();
      n = 0;
      do begin tick(); n++; end while (bus.done !== 1'b1 && n < 30);
      checks++;
      if (n != 20) begin
        errors++; $display("FAIL random_latency pair%0d: %0d, expected 20", i, n);
        break;
      end
    end
    bus.start = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_known_vectors();
    test_back_to_back();
    test_reset_mid();
    test_random_xcheck();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pending_results: %0d left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_iter.md
# aes_decrypt_iter

Iterative AES-128 decryption core: the inverse of the team's combinational AES-128 encryption datapath. It accepts one 128-bit ciphertext and the original 128-bit cipher key, then returns the plaintext one round per clock. It first runs the forward key schedule to reach round key 10, then walks the schedule backwards while executing the inverse rounds. It is the receive-side block that pairs with the encryptor.

## Interface
Parameters: none. AES-128 only; Nk=4, Nr=10 fixed.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only while idle (busy=0)
- data  in  [0:127]  ciphertext; sampled with start
- key  in  [0:127]  cipher key (round key 0); sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: de_data valid
- de_data  out  [0:127]  plaintext result

Bit order:
- Bit 0 is the MSB; byte n = bits [8n:8n+7].
- Byte n sits at state row n%4, column n/4 (FIPS-197 column-major).

## Operation
Internal registers:
- st: 128-bit state
- rk: 128-bit round key
- cnt: 4-bit round counter
- fsm: IDLE / KEXP / ROUND

Rcon table indexed by cnt 0..9: 01,02,04,08,10,20,40,80,1b,36 (placed in byte 0 of the word).

- IDLE:
  - On start=1: st<=data, rk<=key, cnt<=0, busy<=1, go to KEXP.
  - On start=0: hold everything.
- KEXP (10 cycles, cnt 0..9):
  - rk <= forward expansion of rk with Rcon[cnt]:
    - w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon
    - w1' = w1 ^ w0'
    - w2' = w2 ^ w1'
    - w3' = w3 ^ w2'
  - cnt<9: cnt<=cnt+1.
  - cnt=9: also st <= st ^ (new rk), i.e. the initial AddRoundKey with round key 10. Keep cnt=9, go to ROUND.
- ROUND (10 cycles, cnt 9 down to 0):
  - Inverse key step with Rcon[cnt] produces round key cnt:
    - w3 = w3' ^ w2'
    - w2 = w2' ^ w1'
    - w1 = w1' ^ w0'
    - w0 = w0' ^ SubWord(RotWord(w3)) ^ Rcon, using the recovered w3
  - rk <= the recovered round key.
  - t = InvSubBytes(InvShiftRows(st)) ^ (recovered round key). InvShiftRows rotates row r right by r.
  - cnt≠0: st <= InvMixColumns(t), using matrix rows {0e,0b,0d,09} rotated, GF(2^8) modulo 0x11b. Then cnt<=cnt-1.
  - cnt=0: st<=t, de_data<=t, done<=1, busy<=0, go to IDLE.
- Datapath hardware:
  - Exactly one round of datapath: 16 inverse S-boxes and one InvMixColumns.
  - Key path: 4 forward S-boxes for SubWord, shared by KEXP and ROUND. Only one of the two states is active at a time, so a mux selects the SubWord input.
- de_data holds its value until the next completion or reset; it is not cleared on a new start.
- While busy=1, start, data and key are ignored; data and key need not be held stable after sampling.

## Timing
- Reset values: busy=0, done=0, de_data=0, fsm=IDLE, st=0, rk=0, cnt=0.
- Reset has priority over every other event. Reset asserted mid-operation aborts it: no done pulse, outputs return to their reset values on the next edge.
- Latency:
  - start sampled at edge T.
  - busy=1 after edges T+1 .. T+19.
  - de_data valid and done=1 after edge T+20; busy=0 in that same cycle.
  - Total 20 cycles per block; no pipelining.
- done is high for exactly one cycle and falls at edge T+21 unless a new completion occurs there.
- start=1 in the done cycle is accepted (fsm is IDLE). Back-to-back throughput is one block per 20 cycles.
- start held high continuously restarts immediately after every completion, each time using the data/key present at the accepting edge.

## Test plan
- FIPS-197 App. B:
  - Stimulus: key=2b7e151628aed2a6abf7158809cf4f3c, data=3925841d02dc09fbdc118597196a0b32, start for one cycle.
  - Required: de_data=3243f6a8885a308d313198a2e0370734 with done exactly 20 edges after start sampled; busy high in between.
- FIPS-197 C.1:
  - Stimulus: key=000102030405060708090a0b0c0d0e0f, data=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: de_data=00112233445566778899aabbccddeeff.
- All-zero key:
  - Stimulus: key=0, data=66e94bd4ef8a2c3b884cfa59ca342b2e.
  - Required: de_data=0.
- Busy and back-to-back:
  - Stimulus: pulse start with the App. B vector, then change data/key and pulse start during busy cycles 5 and 12; then assert start in the done cycle with the C.1 vector.
  - Required: first result equals the App. B plaintext. Mid-run starts are ignored. Second done comes 20 edges later with the C.1 plaintext.
- Reset mid-operation:
  - Stimulus: assert rst at busy cycle 7 for one cycle.
  - Required: busy=0, done=0, de_data=0 on the next edge; no done pulse follows. A new start afterwards completes correctly.
- Cross-check against the encryptor:
  - Stimulus: 1000 random key/plaintext pairs through the combinational encryptor, with each ciphertext fed to this block.
  - Required: recovered plaintext matches on every pair.
